// File: rtl/lut_bank_pkg.sv
// Shared types and constants for the programmable truth-table bank.
package lut_bank_pkg;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  localparam int unsigned NInDefault = 4;
  localparam int unsigned NChDefault = 10;

  function automatic int unsigned tbl_width(input int unsigned n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/lut_bank_ch.sv
// One channel of the truth-table bank: a TW-bit table register and its index mux.
module lut_bank_ch
  import lut_bank_pkg::*;
#(
  parameter int unsigned N_IN = NInDefault,
  localparam int unsigned TW  = tbl_width(N_IN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [TW-1:0]   data_i,
  input  logic [N_IN-1:0] idx_i,
  output logic            bit_o
);

  logic [TW-1:0] tbl_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q <= '0;
    end else if (we_i) begin
      tbl_q <= data_i;
    end
  end

  // Reads the pre-write table, so a same-cycle eval sees the old function.
  assign bit_o = tbl_q[idx_i];

endmodule

// File: rtl/lut_bank.sv
// Registered bank of N_CH programmable N_IN-input Boolean functions.
// Optional sweep engine enabled by defining LUT_BANK_SWEEP_EN.
module lut_bank
  import lut_bank_pkg::*;
#(
  parameter int unsigned N_IN = NInDefault,
  parameter int unsigned N_CH = NChDefault,
  localparam int unsigned TW  = tbl_width(N_IN),
  localparam int unsigned CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [CW-1:0]   cfg_ch_i,
  input  logic [TW-1:0]   cfg_data_i,
  output logic            cfg_err_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N_IN-1:0] in_vec_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N_CH-1:0] out_vec_o,
  output logic [N_IN-1:0] out_idx_o,
  input  logic            sweep_start_i,
  output logic            sweep_busy_o,
  output logic            sweep_done_o
);

  logic            idle;
  logic            out_free;
  logic            cfg_fire;
  logic            eval_fire;
  logic            sweep_load;
  logic            load;
  logic [N_IN-1:0] sweep_idx;
  logic [N_IN-1:0] idx_sel;
  logic [N_CH-1:0] ch_bits;

  logic            out_valid_q;
  logic [N_CH-1:0] out_vec_q;
  logic [N_IN-1:0] out_idx_q;
  logic            cfg_err_q;

  assign out_free    = !out_valid_q || out_ready_i;
  assign cfg_ready_o = idle;
  assign in_ready_o  = idle && out_free;
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;
  assign eval_fire   = in_valid_i && in_ready_o;
  assign load        = eval_fire || sweep_load;
  assign idx_sel     = sweep_load ? sweep_idx : in_vec_i;

`ifdef LUT_BANK_SWEEP_EN
  state_e          state_q, state_d;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic            wrapped_q, wrapped_d;
  logic            done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wrapped_d  = wrapped_q;
    done_d     = 1'b0;
    sweep_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sweep_start_i) begin
          state_d   = StSweep;
          cnt_d     = '0;
          wrapped_d = 1'b0;
        end
      end
      StSweep: begin
        // wrapped_q marks that index TW-1 is loaded and only its acceptance remains.
        if (!wrapped_q) begin
          if (out_free) begin
            sweep_load = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            wrapped_d  = &cnt_q;
          end
        end else if (out_valid_q && out_ready_i) begin
          state_d   = StIdle;
          wrapped_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  assign idle         = (state_q == StIdle);
  assign sweep_idx    = cnt_q;
  assign sweep_busy_o = (state_q == StSweep);
  assign sweep_done_o = done_q;
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start_i;
  assign idle               = 1'b1;
  assign sweep_load         = 1'b0;
  assign sweep_idx          = '0;
  assign sweep_busy_o       = 1'b0;
  assign sweep_done_o       = 1'b0;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lut_bank_ch #(
      .N_IN(N_IN)
    ) u_ch (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .we_i  (cfg_fire && (32'(cfg_ch_i) == c)),
      .data_i(cfg_data_i),
      .idx_i (idx_sel),
      .bit_o (ch_bits[c])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_idx_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_fire && (32'(cfg_ch_i) >= N_CH);
      if (load) begin
        out_valid_q <= 1'b1;
        out_vec_q   <= ch_bits;
        out_idx_q   <= idx_sel;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_vec_o   = out_vec_q;
  assign out_idx_o   = out_idx_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_lut_bank.sv
// Directed self-checking bench for lut_bank (N_IN=4, N_CH=10).
module tb_lut_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_valid, cfg_ready, cfg_err;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_data;
  logic        in_valid, in_ready;
  logic [3:0]  in_vec;
  logic        out_valid, out_ready;
  logic [9:0]  out_vec;
  logic [3:0]  out_idx;
  logic        sweep_start, sweep_busy, sweep_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  lut_bank #(
    .N_IN(4),
    .N_CH(10)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ch_i     (cfg_ch),
    .cfg_data_i   (cfg_data),
    .cfg_err_o    (cfg_err),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_vec_i     (in_vec),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_vec_o    (out_vec),
    .out_idx_o    (out_idx),
    .sweep_start_i(sweep_start),
    .sweep_busy_o (sweep_busy),
    .sweep_done_o (sweep_done)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef LUT_BANK_SWEEP_EN
  task automatic run_sweep(input bit toggle);
    logic [15:0] pat;
    int          k;
    int          done_cnt;
    pat         = 16'hF0F0;
    k           = 0;
    done_cnt    = 0;
    out_ready   = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("sweep_busy", sweep_busy, 1);
    for (int cyc = 0; cyc < 120 && done_cnt == 0; cyc++) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      #1;
      chk("sweep_cfg_ready", cfg_ready, 0);
      chk("sweep_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("sweep_idx", out_idx, k);
        chk("sweep_vec", out_vec, {31'd0, pat[k[3:0]]});
        k++;
      end
      tick();
      if (sweep_done) done_cnt++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sweep_done) done_cnt++;
    end
    chk("sweep_count", k, 16);
    chk("sweep_done_cnt", done_cnt, 1);
    chk("sweep_idle", sweep_busy, 0);
  endtask
`endif

  initial begin
    rst_ni      = 1'b0;
    cfg_valid   = 1'b0;
    cfg_ch      = '0;
    cfg_data    = '0;
    in_valid    = 1'b0;
    in_vec      = '0;
    out_ready   = 1'b1;
    sweep_start = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_sweep_busy", sweep_busy, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 1);

    // Write ch2 = 8001, then three back-to-back evals.
    cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_data = 16'h8001;
    tick();
    cfg_valid = 1'b0;
    chk("wr_cfg_err", cfg_err, 0);
    in_valid = 1'b1; in_vec = 4'hF;
    tick();
    chk("b2b_valid0", out_valid, 1);
    chk("b2b_vec0", out_vec, 32'h004);
    chk("b2b_idx0", out_idx, 4'hF);
    in_vec = 4'h0;
    tick();
    chk("b2b_vec1", out_vec, 32'h004);
    chk("b2b_idx1", out_idx, 4'h0);
    in_vec = 4'h5;
    tick();
    chk("b2b_vec2", out_vec, 32'h000);
    chk("b2b_idx2", out_idx, 4'h5);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", out_valid, 0);

    // Backpressure: hold out_ready low for 3 cycles with a new input pending.
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'hF;
    tick();
    chk("bp_valid", out_valid, 1);
    in_vec = 4'h5;
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_vec", out_vec, 32'h004);
      chk("bp_hold_idx", out_idx, 4'hF);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_next_idx", out_idx, 4'h5);
    chk("bp_next_vec", out_vec, 32'h000);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 0);

    // Same-cycle write and eval: eval sees the old table.
    cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_data = 16'hFFFF;
    in_valid  = 1'b1; in_vec = 4'h3;
    tick();
    cfg_valid = 1'b0;
    chk("same_cyc_old", out_vec, 32'h000);
    tick();
    chk("same_cyc_new", out_vec, 32'h001);
    in_valid = 1'b0;
    tick();

    // Out-of-range channel write.
    cfg_valid = 1'b1; cfg_ch = 4'd12; cfg_data = 16'h0000;
    tick();
    cfg_valid = 1'b0;
    chk("err_pulse", cfg_err, 1);
    tick();
    chk("err_clear", cfg_err, 0);
    in_valid = 1'b1; in_vec = 4'hF;
    tick();
    chk("err_tables_f", out_vec, 32'h005);
    in_vec = 4'h5;
    tick();
    chk("err_tables_5", out_vec, 32'h001);

    // Reset mid-stream with a held result.
    out_ready = 1'b0; in_vec = 4'hF;
    tick();
    chk("mid_valid", out_valid, 1);
    in_valid = 1'b0;
    rst_ni   = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_vec", out_vec, 0);
    tick();
    rst_ni    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1; in_vec = 4'h5;
    tick();
    chk("post_rst_idx", out_idx, 4'h5);
    chk("post_rst_vec5", out_vec, 0);
    in_vec = 4'hF;
    tick();
    chk("post_rst_vecf", out_vec, 0);
    in_valid = 1'b0;
    tick();

`ifdef LUT_BANK_SWEEP_EN
    cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_data = 16'hF0F0;
    tick();
    cfg_valid = 1'b0;
    tick();
    run_sweep(1'b0);
    run_sweep(1'b1);
`else
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("nosweep_busy", sweep_busy, 0);
    chk("nosweep_cfg_ready", cfg_ready, 1);
    chk("nosweep_valid", out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_bank.md
# lut_bank

Registered, programmable truth-table evaluator for the ALU datapath. It holds N_CH independent Boolean functions of N_IN inputs, each stored as a 2^N_IN-bit truth table loaded at run time. It evaluates all channels on one input vector per handshake, with one output register stage. An optional sweep engine steps through every input combination and streams the results for bring-up and self-check.

## Interface
- N_IN, 4, number of function inputs (2..6); table width TW = 2^N_IN
- N_CH, 10, number of output channels (1..32); CW = max(1, $clog2(N_CH))
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; clk is the only clock
- cfg_valid  in  1  table write request
- cfg_ready  out  1  table write accepted when high with cfg_valid
- cfg_ch  in  CW  target channel
- cfg_data  in  TW  truth table; bit k = f(in_vec == k)
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch >= N_CH
- in_valid  in  1  evaluate request
- in_ready  out  1  input accepted when high with in_valid
- in_vec  in  N_IN  function inputs; bit N_IN-1 is MSB of table index
- out_valid  out  1  result held until accepted
- out_ready  in  1  downstream accepts result
- out_vec  out  N_CH  bit c = table[c][index]
- out_idx  out  N_IN  table index that produced out_vec
- sweep_start  in  1  begin sweep (only with LUT_BANK_SWEEP_EN)
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse after the last sweep result is accepted

## Operation
- Reset (async assert, sync release): all tables 0; out_valid 0; out_vec 0; out_idx 0; cfg_err 0; sweep_busy 0; sweep_done 0; FSM IDLE; sweep counter 0.
- Table write: occurs on cfg_valid & cfg_ready, at the next edge.
  - cfg_ready = 1 in IDLE and 0 in SWEEP.
  - If cfg_ch >= N_CH, the write is dropped and cfg_err pulses next cycle.
- Eval: occurs on in_valid & in_ready.
  - out_vec and out_idx load from the current tables and in_vec.
  - out_valid is set.
  - in_ready = (state == IDLE) & (!out_valid | out_ready). Full throughput with back-to-back acceptance.
- Output: out_valid clears on out_ready when no new eval loads in the same cycle. out_vec and out_idx are stable while out_valid & !out_ready.
- Simultaneous write + eval in the same cycle: the eval uses the old table contents. The write is visible to evals accepted from the next cycle on.
- FSM has two states: IDLE and SWEEP.
  - IDLE→SWEEP on sweep_start. sweep_start is ignored if already in SWEEP. Counter clears to 0.
  - In SWEEP, the counter is the source index. A result loads whenever !out_valid | out_ready, and the counter then increments.
  - After index TW-1 is loaded, the counter wraps to 0. The FSM stays in SWEEP until that result is accepted.
  - When that result is accepted: sweep_done pulses and the FSM returns to IDLE.
- sweep_busy = (state == SWEEP).
- An asserted rst_n low at any time aborts sweeps and writes immediately. Tables return to 0.

## Timing
- Eval latency: 1 cycle from accept to out_valid.
- Sweep: with out_ready held high, results appear on TW consecutive cycles starting 1 cycle after sweep_start. sweep_done is asserted in the cycle after the last accept. Total TW+1 cycles.
- Table write to first eval that uses the new contents: accepted write in cycle t, eval accepted in cycle t+1 or later.
- No combinational path from in_valid to in_ready, or from cfg_valid to cfg_ready. in_ready does depend combinationally on out_ready.

## Configuration
- LUT_BANK_SWEEP_EN defined: the sweep counter, SWEEP state and sweep outputs are implemented as above.
- LUT_BANK_SWEEP_EN undefined:
  - sweep_start is ignored.
  - sweep_busy and sweep_done are tied to 0.
  - The FSM is permanently IDLE and no counter is built.
  - All other behaviour is identical.

## Structure
- Package lut_bank_pkg:
  - state enum {IDLE, SWEEP}
  - function for table width (2**n)
  - default parameter constants for N_IN and N_CH
- Sub-module lut_bank_ch: one table register plus its index mux, instantiated N_CH times with generate.
- The FSM, handshakes and output register stay in the top level.

## Test plan
All scenarios use N_IN=4, N_CH=10.
1. Reset: drive rst_n low mid-stream with out_valid high → out_valid=0, out_vec=0, and all tables read 0 on the next eval of 4'h5.
2. Write ch2=16'h8001, then eval 4'hF, 4'h0, 4'h5 back-to-back with out_ready high → out_vec[2]=1,1,0 on consecutive cycles; out_idx echoes each input.
3. Hold out_ready low for 3 cycles with in_valid high → out_vec and out_idx stay stable, in_ready=0, and no input is lost after release.
4. Same-cycle write ch0=16'hFFFF and eval 4'h3 (ch0 previously 0) → out_vec[0]=0. The next eval of 4'h3 gives 1.
5. Write cfg_ch=12 → cfg_err pulses for one cycle and all tables are unchanged.
6. With LUT_BANK_SWEEP_EN:
   - Load ch0=16'hF0F0, then pulse sweep_start with out_ready high → out_idx runs 0..15 on 16 consecutive cycles, and out_vec[0] matches bit k of 16'hF0F0.
   - cfg_ready=0 and in_ready=0 throughout.
   - sweep_done pulses once.
   - Repeat with out_ready toggling → still 16 results in order.
